// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among N engines, with a per-grant ack budget.
// Optional ARB_ADDR_WINDOW_EN: offsets each requester's address by (index << WINDOW_SHIFT).
module mem_port_arbiter #(
  parameter int N            = 4,
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int BURST_MAX    = 8,
  parameter int WINDOW_SHIFT = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2*N-1:0]    req_op_i,
  input  logic [AW*N-1:0]   req_addr_i,
  input  logic [DW*N-1:0]   req_wdata_i,
  output logic [N-1:0]      req_opdone_o,
  output logic [DW-1:0]     req_rdata_o,
  output logic [N-1:0]      grant_o,
  output logic [1:0]        mem_op_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  input  logic [DW-1:0]     mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              busy_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(BURST_MAX + 1);
`ifdef ARB_ADDR_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gidx_q, gidx_d, rr_q, rr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [N-1:0]  pend;
  logic          found;
  logic [IW-1:0] sel;
  logic [1:0]    g_op;
  logic          others_pend, burst_hit, release_g;

  for (genvar r = 0; r < N; r++) begin : g_pend
    assign pend[r] = |req_op_i[2*r +: 2];
  end

  // Rotating priority search; walking the offsets downward lets the smallest offset win.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pend[(int'(rr_q) + i) % N]) begin
        found = 1'b1;
        sel   = IW'((int'(rr_q) + i) % N);
      end
    end
  end

  assign g_op        = req_op_i[2*int'(gidx_q) +: 2];
  assign others_pend = |(pend & ~grant_q);
  assign cnt_inc     = (cnt_q == CW'(BURST_MAX)) ? cnt_q : cnt_q + 1'b1;
  // A saturated count still counts as "reaching the budget" once someone else waits.
  assign burst_hit   = mem_ack_i && (cnt_inc == CW'(BURST_MAX)) && others_pend;
  assign release_g   = (g_op == 2'b00) || burst_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        grant_d = N'(1) << sel;
        gidx_d  = sel;
        cnt_d   = '0;
      end
      GRANT: begin
        if (release_g) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = (gidx_q == IW'(N - 1)) ? '0 : gidx_q + 1'b1;
          cnt_d   = '0;
        end else if (mem_ack_i) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_opdone_o = '0;
    req_rdata_o  = mem_rdata_i;
    grant_o      = grant_q;
    mem_op_o     = 2'b00;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    busy_o       = 1'b0;
    if (reset) begin
      req_rdata_o = '0;
      grant_o     = '0;
    end else if (state_q == GRANT) begin
      busy_o       = 1'b1;
      mem_op_o     = g_op;
      mem_addr_o   = req_addr_i[int'(gidx_q)*AW +: AW]
                   + (WIN_EN ? (AW'(gidx_q) << WINDOW_SHIFT) : '0);
      mem_wdata_o  = req_wdata_i[int'(gidx_q)*DW +: DW];
      req_opdone_o = grant_q & {N{mem_ack_i}};
    end
  end

endmodule
